// File: rtl/pc_call_stack_if.sv
// Command/status bundle between the control sequencer and pc_call_stack.
// The sequencer owns the master side; the program counter is the slave.
interface pc_call_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_in;
  logic             C;
  logic             L;
  logic             CALL;
  logic             RET;
  logic             E;
  logic [WIDTH-1:0] pc_q;
  logic [SPW-1:0]   sp;
  logic             stk_full;
  logic             stk_empty;
  logic             err;

  modport master (
    output pc_in, C, L, CALL, RET, E,
    input  pc_q, sp, stk_full, stk_empty, err
  );

  modport slave (
    input  pc_in, C, L, CALL, RET, E,
    output pc_q, sp, stk_full, stk_empty, err
  );
endinterface

// File: rtl/pc_call_stack.sv
// SAP-II program counter with count/load/bus-enable plus a return-address
// stack for CALL/RET, full/empty status and a sticky over/underflow flag.
module pc_call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  pc_call_stack_if.slave   bus,
  output wire  [WIDTH-1:0] pc_w
);
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [SPW-1:0]   r_sp;
  logic [SPW-1:0]   w_sp_next;
  logic             r_err;
  logic             w_err_next;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [WIDTH-1:0] r_stack [SLOTS];

  assign w_full   = (r_sp == SPW'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_wr_idx = AW'(r_sp);
  assign w_rd_idx = AW'(r_sp - SPW'(1));

  // Priority RET > CALL > L > C; a blocked push or pop only raises err.
  always_comb begin
    w_count_next = r_count;
    w_sp_next    = r_sp;
    w_err_next   = r_err;
    w_push       = 1'b0;
    if (bus.RET) begin
      if (w_empty) begin
        w_err_next = 1'b1;
      end else begin
        w_count_next = r_stack[w_rd_idx];
        w_sp_next    = r_sp - SPW'(1);
      end
    end else if (bus.CALL) begin
      if (w_full) begin
        w_err_next = 1'b1;
      end else begin
        w_push       = 1'b1;
        w_sp_next    = r_sp + SPW'(1);
        w_count_next = bus.pc_in;
      end
    end else if (bus.L) begin
      w_count_next = bus.pc_in;
    end else if (bus.C) begin
      w_count_next = r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
      r_sp    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_sp    <= w_sp_next;
      r_err   <= w_err_next;
    end
  end

  // Stack contents survive clr; only the pointer is reset.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_stack[w_wr_idx] <= r_count;
    end
  end

  assign bus.pc_q      = r_count;
  assign bus.sp        = r_sp;
  assign bus.stk_full  = w_full;
  assign bus.stk_empty = w_empty;
  assign bus.err       = r_err;
  assign pc_w          = bus.E ? r_count : {WIDTH{1'bz}};
endmodule

// File: tb/tb_pc_call_stack.sv
// Directed plus randomized checks of pc_call_stack against a queue-based
// return-stack model; a second DEPTH=1 instance covers the single-entry case.
module tb_pc_call_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  wire [WIDTH-1:0] pc_w;
  wire [WIDTH-1:0] pc_w1;

  pc_call_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  pc_call_stack_if #(.WIDTH(WIDTH), .DEPTH(1))     bus1 ();

  pc_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .clr(clr), .bus(bus0), .pc_w(pc_w)
  );
  pc_call_stack #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
    .clk(clk), .clr(clr), .bus(bus1), .pc_w(pc_w1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a plain integer PC and a queue used as the stack.
  int m_count;
  int m_stack[$];
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit l, input bit call, input bit ret, input int pin);
    if (ret) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_count = m_stack.pop_back();
    end else if (call) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stack.push_back(m_count);
        m_count = pin;
      end
    end else if (l) begin
      m_count = pin;
    end else if (c) begin
      m_count = (m_count + 1) % (1 << WIDTH);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_w;
    exp_w = bus0.E ? WIDTH'(m_count) : {WIDTH{1'bz}};
    chk({tag, ".pc_q"}, 32'(bus0.pc_q), 32'(m_count));
    chk({tag, ".sp"}, 32'(bus0.sp), 32'(m_stack.size()));
    chk({tag, ".full"}, 32'(bus0.stk_full), 32'(m_stack.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus0.stk_empty), 32'(m_stack.size() == 0));
    chk({tag, ".err"}, 32'(bus0.err), 32'(m_err));
    chk({tag, ".pc_w"}, {24'h0, pc_w}, {24'h0, exp_w});
    $display("[%0t] %s pc_q=%h sp=%0d err=%0b", $time, tag, bus0.pc_q, bus0.sp, bus0.err);
  endtask

  // One clock with the given commands; inputs change 1 time unit after the edge.
  task automatic cyc(input string tag, input bit c, input bit l, input bit call,
                     input bit ret, input int pin);
    bus0.C = c; bus0.L = l; bus0.CALL = call; bus0.RET = ret;
    bus0.pc_in = WIDTH'(pin);
    @(posedge clk);
    if (!clr) model_step(c, l, call, ret, pin);
    #1;
    bus0.C = 1'b0; bus0.L = 1'b0; bus0.CALL = 1'b0; bus0.RET = 1'b0;
    check_all(tag);
  endtask

  task automatic async_clear(input string tag);
    #1 clr = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 clr = 1'b0;
  endtask

  initial begin
    bus0.pc_in = '0; bus0.C = 0; bus0.L = 0; bus0.CALL = 0; bus0.RET = 0; bus0.E = 0;
    bus1.pc_in = '0; bus1.C = 0; bus1.L = 0; bus1.CALL = 0; bus1.RET = 0; bus1.E = 0;
    model_reset();
    #2;
    check_all("reset");
    cyc("clr_holds_cmd", 1, 0, 0, 0, 0);
    clr = 1'b0;

    // Count and wrap
    cyc("count1", 1, 0, 0, 0, 0);
    cyc("count2", 1, 0, 0, 0, 0);
    cyc("count3", 1, 0, 0, 0, 0);
    cyc("load_ff", 0, 1, 0, 0, 8'hFF);
    cyc("wrap", 1, 0, 0, 0, 0);

    // Bus drive
    bus0.E = 1'b0;
    cyc("load_08", 0, 1, 0, 0, 8'h08);
    bus0.E = 1'b1;
    #1 check_all("e_rise");
    bus0.E = 1'b0;

    // Call/return
    cyc("load_05", 0, 1, 0, 0, 8'h05);
    cyc("call_40", 0, 0, 1, 0, 8'h40);
    cyc("inc_41", 1, 0, 0, 0, 0);
    cyc("inc_42", 1, 0, 0, 0, 0);
    cyc("ret_05", 0, 0, 0, 1, 0);

    // Nesting and overflow
    cyc("load_01", 0, 1, 0, 0, 1);
    for (int i = 2; i <= 5; i++) cyc("nest_call", 0, 0, 1, 0, i);
    cyc("overflow", 0, 0, 1, 0, 8'h77);
    for (int i = 0; i < 4; i++) cyc("nest_ret", 0, 0, 0, 1, 0);
    async_clear("clr_err");

    // Underflow stickiness
    cyc("underflow", 0, 0, 0, 1, 0);
    cyc("sticky_call", 0, 0, 1, 0, 8'h20);
    cyc("sticky_ret", 0, 0, 0, 1, 0);
    async_clear("clr_sticky");

    // Priority
    cyc("pri_call", 0, 0, 1, 0, 8'h10);
    cyc("pri_all", 1, 1, 1, 1, 8'h99);
    cyc("pri_lc", 1, 1, 0, 0, 8'h3C);
    cyc("back_call", 0, 0, 1, 0, 8'h50);
    cyc("back_ret", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("fill3", 0, 0, 1, 0, 8'hA0 + i);
    async_clear("clr_mid_sp3");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      bus0.E = 1'($urandom);
      if ($urandom_range(0, 49) == 0) async_clear("rnd_clr");
      else cyc("rnd", r < 4, r == 4 || r == 5, r == 6 || r == 7, r >= 8 || ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 255)));
    end
    bus0.E = 1'b0;

    // Single-entry stack
    bus1.CALL = 1'b1; bus1.pc_in = 8'h33;
    @(posedge clk); #1;
    chk("d1_call.full", 32'(bus1.stk_full), 32'd1);
    chk("d1_call.err", 32'(bus1.err), 32'd0);
    chk("d1_call.pc_q", 32'(bus1.pc_q), 32'h33);
    $display("[%0t] d1_call pc_q=%h full=%0b", $time, bus1.pc_q, bus1.stk_full);
    bus1.pc_in = 8'h44;
    @(posedge clk); #1;
    bus1.CALL = 1'b0;
    chk("d1_over.err", 32'(bus1.err), 32'd1);
    chk("d1_over.pc_q", 32'(bus1.pc_q), 32'h33);
    $display("[%0t] d1_over pc_q=%h err=%0b", $time, bus1.pc_q, bus1.err);
    bus1.RET = 1'b1;
    @(posedge clk); #1;
    bus1.RET = 1'b0;
    chk("d1_ret.pc_q", 32'(bus1.pc_q), 32'h00);
    chk("d1_ret.empty", 32'(bus1.stk_empty), 32'd1);
    $display("[%0t] d1_ret pc_q=%h empty=%0b", $time, bus1.pc_q, bus1.stk_empty);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
